// File: rtl/asrm_byte_bridge_pkg.sv
// Shared size codes, FSM state encoding and byte-count helper for the byte bridge.
// Little-endian, with the byte count clamped to the CPU word width.
package asrm_byte_bridge_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_32   = 2'b01;
    localparam logic [1:0] SIZE_16   = 2'b10;
    localparam logic [1:0] SIZE_8    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_XFER  = 2'b01,
        ST_FLUSH = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Bytes moved for a size code, never more than the CPU word holds.
    function automatic int unsigned size_bytes(input logic [1:0] size, input int unsigned wbytes);
        int unsigned n;
        case (size)
            SIZE_32: n = 4;
            SIZE_16: n = 2;
            SIZE_8:  n = 1;
            default: n = wbytes;
        endcase
        if (n > wbytes) n = wbytes;
        return n;
    endfunction

endpackage

// File: rtl/asrm_byte_lanes.sv
// Read-assembly lanes and write-byte mux; rdata_o updates one edge after load_i, lanes >= n zeroed.
// No backpressure: captures whatever byte the controller flags.
module asrm_byte_lanes #(
    parameter int WORDSIZE = 16,
    parameter int CW       = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_i,
    input  logic                cap_vld_i,
    input  logic [CW-1:0]       cap_idx_i,
    input  logic [7:0]          cap_byte_i,
    input  logic                load_i,
    input  logic [CW-1:0]       nbytes_i,
    input  logic [CW-1:0]       wsel_i,
    input  logic [WORDSIZE-1:0] wdata_i,
    output logic [WORDSIZE-1:0] rdata_o,
    output logic [7:0]          wbyte_o
);

    localparam int WBYTES = WORDSIZE / 8;

    logic [WBYTES-1:0][7:0] asm_q, asm_d, lane_new;
    logic [WORDSIZE-1:0]    rdata_q, rdata_d;

    always_comb begin
        lane_new = asm_q;
        if (cap_vld_i) begin
            for (int l = 0; l < WBYTES; l++) begin
                if (cap_idx_i == CW'(l)) lane_new[l] = cap_byte_i;
            end
        end
        asm_d = clr_i ? '0 : lane_new;

        // The final byte arrives on the same edge that publishes rdata, so load from lane_new.
        rdata_d = rdata_q;
        if (load_i) begin
            for (int l = 0; l < WBYTES; l++) begin
                rdata_d[8*l +: 8] = (CW'(l) < nbytes_i) ? lane_new[l] : 8'h00;
            end
        end

        wbyte_o = 8'h00;
        for (int l = 0; l < WBYTES; l++) begin
            if (wsel_i == CW'(l)) wbyte_o = wdata_i[8*l +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            asm_q   <= '0;
            rdata_q <= '0;
        end else begin
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/asrm_byte_bridge.sv
// Splits one CPU access into n byte-wide RAM accesses; ready pulses n+1 cycles after the latch edge.
// No backpressure on the RAM side; the core stalls on busy until the ready pulse.
module asrm_byte_bridge
    import asrm_byte_bridge_pkg::*;
#(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [1:0]          size_i,
    input  logic [wordsize-1:0] addr_i,
    input  logic [wordsize-1:0] wdata_i,
    output logic [wordsize-1:0] rdata_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic [wordsize-1:0] ram_addr_o,
    output logic [7:0]          ram_wdata_o,
    output logic                ram_we_o,
    output logic                ram_en_o,
    input  logic [7:0]          ram_rdata_i
);

    localparam int WBYTES = wordsize / 8;
    localparam int CW     = $clog2(WBYTES) + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    state_e              state_q, state_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       n_q, n_d;
    logic [wordsize-1:0] addr_q, addr_d;
    logic [wordsize-1:0] wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                cap_vld_q, cap_vld_d;
    logic [CW-1:0]       cap_idx_q, cap_idx_d;
    logic                latch;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        latch     = 1'b0;
        // A read byte issued this cycle is returned next cycle and captured the edge after.
        cap_vld_d = (state_q == ST_XFER) && !we_q;
        cap_idx_d = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    state_d = ST_XFER;
                    latch   = 1'b1;
                    idx_d   = '0;
                    n_d     = CW'(size_bytes(size_i, WBYTES));
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    we_d    = we_i;
                end
            end
            ST_XFER: begin
                if (idx_q == n_q - ONE) state_d = ST_FLUSH;
                else                    idx_d   = idx_q + ONE;
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            n_q       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
        end
    end

    asrm_byte_lanes #(
        .WORDSIZE (wordsize),
        .CW       (CW)
    ) u_lanes (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (latch),
        .cap_vld_i  (cap_vld_q),
        .cap_idx_i  (cap_idx_q),
        .cap_byte_i (ram_rdata_i),
        .load_i     ((state_q == ST_FLUSH) && !we_q),
        .nbytes_i   (n_q),
        .wsel_i     (idx_q),
        .wdata_i    (wdata_q),
        .rdata_o    (rdata_o),
        .wbyte_o    (ram_wdata_o)
    );

    // Strobes are masked while reset is asserted so an aborted write never reaches the RAM.
    assign ram_en_o   = (state_q == ST_XFER) && reset;
    assign ram_we_o   = ram_en_o && we_q;
    assign ram_addr_o = addr_q + {{(wordsize-CW){1'b0}}, idx_q};
    assign ready_o    = (state_q == ST_DONE);
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_asrm_byte_bridge.sv
// Bench for asrm_byte_bridge at wordsize 16 and 32 with byte-RAM models and a timeline model.
module tb_asrm_byte_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic        rst16 = 1'b0, req16 = 1'b0, we16 = 1'b0;
    logic [1:0]  size16 = 2'b00;
    logic [15:0] addr16 = '0, wdata16 = '0;
    logic [15:0] rdata16, raddr16;
    logic        ready16, busy16, rwe16, ren16;
    logic [7:0]  rwd16, rrd16;

    logic        rst32 = 1'b0, req32 = 1'b0, we32 = 1'b0;
    logic [1:0]  size32 = 2'b00;
    logic [31:0] addr32 = '0, wdata32 = '0;
    logic [31:0] rdata32, raddr32;
    logic        ready32, busy32, rwe32, ren32;
    logic [7:0]  rwd32, rrd32;

    asrm_byte_bridge #(.wordsize(16)) u16 (
        .clk(clk), .reset(rst16), .req_i(req16), .we_i(we16), .size_i(size16),
        .addr_i(addr16), .wdata_i(wdata16), .rdata_o(rdata16), .ready_o(ready16),
        .busy_o(busy16), .ram_addr_o(raddr16), .ram_wdata_o(rwd16), .ram_we_o(rwe16),
        .ram_en_o(ren16), .ram_rdata_i(rrd16)
    );

    asrm_byte_bridge #(.wordsize(32)) u32 (
        .clk(clk), .reset(rst32), .req_i(req32), .we_i(we32), .size_i(size32),
        .addr_i(addr32), .wdata_i(wdata32), .rdata_o(rdata32), .ready_o(ready32),
        .busy_o(busy32), .ram_addr_o(raddr32), .ram_wdata_o(rwd32), .ram_we_o(rwe32),
        .ram_en_o(ren32), .ram_rdata_i(rrd32)
    );

    // Byte-wide synchronous RAMs; the 32-bit side only decodes the low address byte.
    logic [7:0] mem16 [0:65535];
    logic [7:0] mem32 [0:255];
    always @(posedge clk) begin
        if (ren16) begin
            if (rwe16) mem16[raddr16] = rwd16;
            else       rrd16 <= mem16[raddr16];
        end
        if (ren32) begin
            if (rwe32) mem32[raddr32[7:0]] = rwd32;
            else       rrd32 <= mem32[raddr32[7:0]];
        end
    end

    typedef struct {
        int          e0;
        int          n;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } txn_t;

    txn_t        q16[$], q32[$];
    logic [31:0] lastr16 = '0, lastr32 = '0;
    int          rdy_cyc16 = -1, rdy_cyc32 = -1;
    int          we_cnt16 = 0, en_cnt32 = 0;

    always @(negedge clk) begin
        if (rwe16) we_cnt16++;
        if (ren32) en_cnt32++;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] sz, input int wbytes);
        int n;
        case (sz)
            2'b00:   n = wbytes;
            2'b01:   n = 4;
            2'b10:   n = 2;
            default: n = 1;
        endcase
        return (n > wbytes) ? wbytes : n;
    endfunction

    // Timeline of one access: bytes at k=0..n-1 after the latch edge, ready at k=n+1.
    task automatic check_cycle(input string tag, input bit have, input txn_t t,
                               input logic [31:0] lastr, input logic [31:0] amask,
                               input logic en, input logic wen, input logic rdy, input logic bsy,
                               input logic [31:0] ra, input logic [7:0] wd, input logic [31:0] rd,
                               output bit done);
        int k;
        bit x_en, x_rdy, x_bsy;
        k     = have ? cyc - t.e0 : -1;
        x_en  = have && k >= 0 && k < t.n;
        x_rdy = have && k == t.n + 1;
        x_bsy = have && k >= 0 && k <= t.n + 1;
        cmp({tag, ".ram_en"}, 32'(en), 32'(x_en));
        cmp({tag, ".ram_we"}, 32'(wen), 32'(x_en && t.we));
        cmp({tag, ".ready"}, 32'(rdy), 32'(x_rdy));
        cmp({tag, ".busy"}, 32'(bsy), 32'(x_bsy));
        if (x_en) begin
            cmp({tag, ".ram_addr"}, ra, (t.addr + 32'(k)) & amask);
            if (t.we) cmp({tag, ".ram_wdata"}, 32'(wd), (t.wdata >> (8*k)) & 32'hFF);
        end
        cmp({tag, ".rdata"}, rd, (x_rdy && !t.we) ? t.exp_rdata : lastr);
        done = x_rdy;
    endtask

    always @(negedge clk) begin
        txn_t t;
        bit   have, done;
        if (!rst16) begin
            q16.delete();
            lastr16 = '0;
        end else begin
            have = (q16.size() > 0);
            if (have) t = q16[0];
            check_cycle("d16", have, t, lastr16, 32'h0000FFFF, ren16, rwe16, ready16, busy16,
                        32'(raddr16), rwd16, 32'(rdata16), done);
            if (done) begin
                if (!t.we) lastr16 = t.exp_rdata;
                void'(q16.pop_front());
            end
            if (ready16) rdy_cyc16 = cyc;
        end
    end

    always @(negedge clk) begin
        txn_t t;
        bit   have, done;
        if (!rst32) begin
            q32.delete();
            lastr32 = '0;
        end else begin
            have = (q32.size() > 0);
            if (have) t = q32[0];
            check_cycle("d32", have, t, lastr32, 32'hFFFFFFFF, ren32, rwe32, ready32, busy32,
                        raddr32, rwd32, rdata32, done);
            if (done) begin
                if (!t.we) lastr32 = t.exp_rdata;
                void'(q32.pop_front());
            end
            if (ready32) rdy_cyc32 = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t mk32(input int e0, input logic w, input logic [1:0] sz,
                                  input logic [31:0] a, input logic [31:0] wd);
        txn_t        t;
        logic [31:0] ak;
        t.e0 = e0; t.n = nb(sz, 4); t.addr = a; t.we = w; t.wdata = wd; t.exp_rdata = '0;
        for (int k = 0; k < t.n; k++) begin
            ak = a + 32'(k);
            t.exp_rdata |= 32'(mem32[ak[7:0]]) << (8*k);
        end
        return t;
    endfunction

    task automatic go16(input logic w, input logic [1:0] sz, input logic [15:0] a,
                        input logic [15:0] wd, output int e0);
        txn_t t;
        e0 = cyc + 1;
        t.e0 = e0; t.n = nb(sz, 2); t.addr = 32'(a); t.we = w; t.wdata = 32'(wd); t.exp_rdata = '0;
        for (int k = 0; k < t.n; k++) t.exp_rdata |= 32'(mem16[a + 16'(k)]) << (8*k);
        q16.push_back(t);
        req16 = 1'b1; we16 = w; size16 = sz; addr16 = a; wdata16 = wd;
        tick();
        req16 = 1'b0; we16 = ~w; addr16 = ~a; wdata16 = ~wd;
        repeat (t.n + 2) tick();
    endtask

    task automatic go32(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output int e0);
        txn_t t;
        e0 = cyc + 1;
        t  = mk32(e0, w, sz, a, wd);
        q32.push_back(t);
        req32 = 1'b1; we32 = w; size32 = sz; addr32 = a; wdata32 = wd;
        tick();
        req32 = 1'b0; we32 = ~w; addr32 = ~a; wdata32 = ~wd;
        repeat (t.n + 2) tick();
    endtask

    initial begin
        int e0, base;
        for (int i = 0; i < 65536; i++) mem16[i] = 8'h00;
        for (int i = 0; i < 256; i++)   mem32[i] = 8'h00;
        mem16[16'h0010] = 8'h34; mem16[16'h0011] = 8'h12;
        mem16[16'hFFFF] = 8'h22; mem16[16'h0000] = 8'h11;
        mem32[8'h05] = 8'hA5;
        mem32[8'h60] = 8'h78; mem32[8'h61] = 8'h56; mem32[8'h62] = 8'h34; mem32[8'h63] = 8'h12;
        mem32[8'h80] = 8'hCD; mem32[8'h81] = 8'hAB;

        repeat (3) tick();
        cmp("rst16.rdata", 32'(rdata16), 0);  cmp("rst16.ready", 32'(ready16), 0);
        cmp("rst16.busy", 32'(busy16), 0);    cmp("rst16.ram_addr", 32'(raddr16), 0);
        cmp("rst16.ram_wdata", 32'(rwd16), 0); cmp("rst16.ram_we", 32'(rwe16), 0);
        cmp("rst16.ram_en", 32'(ren16), 0);
        cmp("rst32.rdata", rdata32, 0);       cmp("rst32.ready", 32'(ready32), 0);
        cmp("rst32.busy", 32'(busy32), 0);    cmp("rst32.ram_addr", raddr32, 0);
        cmp("rst32.ram_wdata", 32'(rwd32), 0); cmp("rst32.ram_we", 32'(rwe32), 0);
        cmp("rst32.ram_en", 32'(ren32), 0);
        rst16 = 1'b1; rst32 = 1'b1;
        tick();

        go16(1'b0, 2'b00, 16'h0010, 16'h0000, e0);
        cmp("t1.rdata", 32'(rdata16), 32'h1234);
        cmp("t1.ready_lat", 32'(rdy_cyc16 - e0), 3);

        base = we_cnt16;
        go16(1'b1, 2'b00, 16'h0020, 16'hBEEF, e0);
        cmp("t2.mem20", 32'(mem16[16'h0020]), 32'hEF);
        cmp("t2.mem21", 32'(mem16[16'h0021]), 32'hBE);
        cmp("t2.we_cycles", 32'(we_cnt16 - base), 2);
        cmp("t2.ready_lat", 32'(rdy_cyc16 - e0), 3);
        cmp("t2.rdata_held", 32'(rdata16), 32'h1234);

        go16(1'b0, 2'b00, 16'hFFFF, 16'h0000, e0);
        cmp("t4.rdata_wrap", 32'(rdata16), 32'h1122);
        go16(1'b0, 2'b11, 16'h0011, 16'h0000, e0);
        cmp("t16.size8", 32'(rdata16), 32'h0012);
        go16(1'b0, 2'b01, 16'h0010, 16'h0000, e0);
        cmp("t16.size32_clamp", 32'(rdata16), 32'h1234);
        cmp("t16.clamp_lat", 32'(rdy_cyc16 - e0), 3);

        base = en_cnt32;
        go32(1'b0, 2'b11, 32'h5, 32'h0, e0);
        cmp("t3.rdata", rdata32, 32'h000000A5);
        cmp("t3.en_cycles", 32'(en_cnt32 - base), 1);
        cmp("t3.ready_lat", 32'(rdy_cyc32 - e0), 2);
        go32(1'b0, 2'b00, 32'h60, 32'h0, e0);
        cmp("t32.word", rdata32, 32'h12345678);

        // Abort a full-word write by asserting reset during its second byte.
        e0 = cyc + 1;
        q32.push_back(mk32(e0, 1'b1, 2'b00, 32'h40, 32'hDDCCBBAA));
        req32 = 1'b1; we32 = 1'b1; size32 = 2'b00; addr32 = 32'h40; wdata32 = 32'hDDCCBBAA;
        tick();
        req32 = 1'b0;
        tick();
        rst32 = 1'b0;
        #1;
        cmp("t5.en_in_rst", 32'(ren32), 0);
        cmp("t5.we_in_rst", 32'(rwe32), 0);
        tick();
        rst32 = 1'b1;
        #1;
        cmp("t5.busy", 32'(busy32), 0);     cmp("t5.ready", 32'(ready32), 0);
        cmp("t5.rdata", rdata32, 0);        cmp("t5.ram_addr", raddr32, 0);
        cmp("t5.ram_wdata", 32'(rwd32), 0); cmp("t5.ram_en", 32'(ren32), 0);
        cmp("t5.ram_we", 32'(rwe32), 0);
        tick(); tick();
        cmp("t5.mem40", 32'(mem32[8'h40]), 32'hAA);
        cmp("t5.mem41", 32'(mem32[8'h41]), 32'h00);
        cmp("t5.mem42", 32'(mem32[8'h42]), 32'h00);

        // Back-to-back 16-bit reads with req held; address changes while busy take effect next access.
        e0 = cyc + 1;
        q32.push_back(mk32(e0, 1'b0, 2'b10, 32'h80, 32'h0));
        q32.push_back(mk32(e0 + 5, 1'b0, 2'b10, 32'h60, 32'h0));
        req32 = 1'b1; we32 = 1'b0; size32 = 2'b10; addr32 = 32'h80;
        tick();
        addr32 = 32'h60;
        repeat (3) tick();
        cmp("t6.ready_a", 32'(ready32), 1);
        cmp("t6.rdata_a", rdata32, 32'h0000ABCD);
        tick();
        cmp("t6.gap", 32'(ready32), 0);
        tick();
        req32 = 1'b0;
        repeat (3) tick();
        cmp("t6.ready_b", 32'(ready32), 1);
        cmp("t6.rdata_b", rdata32, 32'h00005678);
        repeat (3) tick();

        cmp("drain16", 32'(q16.size()), 0);
        cmp("drain32", 32'(q32.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
